// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- RV32I instruction fetch stage with a 2-entry fetch queue.
//
// Issues one instruction-memory read at a time, queues up to two fetched
// {pc, instr} pairs for decode and recovers from redirects. A redirect that
// arrives while a read is still in flight lets that read complete and throws
// its data away (S_DROP) before fetching from the new target.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   imem_read     out  read request, held high until imem_resp
//   imem_address  out  word-aligned read address, stable while imem_read=1
//   imem_resp     in   one-cycle read completion strobe
//   imem_rdata    in   instruction word, valid with imem_resp
//   redirect      in   taken branch / jump from execute
//   redirect_pc   in   redirect target, valid with redirect
//   dec_ready     in   decode accepts the head entry this cycle
//   dec_valid     out  head entry present
//   dec_instr     out  head instruction (NOP 0x00000013 when empty)
//   dec_pc        out  head PC (0 when empty)
//   opcode        out  dec_instr[6:0]
//   funct3        out  dec_instr[14:12]
//   funct7        out  dec_instr[31:25]
//   s_imm         out  S-type immediate of dec_instr, sign-extended
//   fetch_count   out  dequeue counter
//   stall_count   out  empty-head cycle counter
//
// Build option
//   FETCH_PERF_CNT_EN  when defined, fetch_count/stall_count are live 32-bit
//                      wrapping counters; otherwise both are tied to zero and
//                      no counter registers exist.
// -----------------------------------------------------------------------------

package rv32i_types_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

endpackage

module instr_fetch
    import rv32i_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output rv32i_opcode opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] s_imm,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    localparam logic [31:0] RESET_PC  = 32'h0000_0060;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          DEPTH     = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // r_pc is the next address to fetch; r_addr is the address on the bus.
    // They differ while draining a dropped read, where the bus must keep the
    // old address even though r_pc already points at the redirect target.
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:2] r_addr;

    logic [31:0] r_fifo_pc    [DEPTH];
    logic [31:0] r_fifo_instr [DEPTH];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic [1:0]  w_occ_after;
    logic [DEPTH-1:0] w_wr_en;

    logic        w_enq;
    logic        w_deq;
    logic        w_flush;

    // -------------------------------------------------------------------------
    // Queue handshakes
    // -------------------------------------------------------------------------
    // A redirect squashes whatever decode would have taken this cycle.
    assign w_deq = dec_valid && dec_ready && !redirect;

    // Occupancy after this cycle's enqueue/dequeue; used to decide whether
    // another read may be launched back-to-back without risking overflow.
    assign w_occ_after = r_count + 2'd1 - {1'b0, w_deq};

    // -------------------------------------------------------------------------
    // Next-state / next-pc logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_enq        = 1'b0;
        w_flush      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_flush   = 1'b1;
                    w_pc_next = redirect_pc;
                end else if (r_count < 2'd2) begin
                    w_state_next = S_REQ;
                end
            end

            S_REQ: begin
                if (redirect) begin
                    w_flush   = 1'b1;
                    w_pc_next = redirect_pc;
                    // Data arriving right now is simply not enqueued; a read
                    // still in flight has to be drained first.
                    w_state_next = imem_resp ? S_IDLE : S_DROP;
                end else if (imem_resp) begin
                    w_enq        = 1'b1;
                    w_pc_next    = r_pc + 32'd4;
                    w_state_next = (w_occ_after < 2'd2) ? S_REQ : S_IDLE;
                end
            end

            S_DROP: begin
                // The queue is already empty here, so a redirect only has to
                // retarget the fetch that follows the drained read.
                if (redirect) begin
                    w_pc_next = redirect_pc;
                end
                if (imem_resp) begin
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        if (w_flush) begin
            w_count_next = 2'd0;
        end else begin
            w_count_next = r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    // -------------------------------------------------------------------------
    // State, pc and bus address registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC[31:2];
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            // Whenever a fetch is (or stays) on the bus next cycle it targets
            // the next pc; in S_DROP the drained address is left untouched.
            if (w_state_next == S_REQ) begin
                r_addr <= w_pc_next[31:2];
            end
        end
    end

    assign imem_read    = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_address = {r_addr, 2'b00};

    // -------------------------------------------------------------------------
    // Two-entry fetch queue
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_enq && (r_wr_ptr == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]    <= 32'd0;
                r_fifo_instr[i] <= NOP_INSTR;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en[i]) begin
                    r_fifo_pc[i]    <= r_pc;
                    r_fifo_instr[i] <= imem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_count <= w_count_next;
            if (w_flush) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_deq) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decode-side outputs
    // -------------------------------------------------------------------------
    assign dec_valid = (r_count != 2'd0);
    assign dec_instr = dec_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
    assign dec_pc    = dec_valid ? r_fifo_pc[r_rd_ptr]    : 32'd0;

    assign opcode = rv32i_opcode'(dec_instr[6:0]);
    assign funct3 = dec_instr[14:12];
    assign funct7 = dec_instr[31:25];
    assign s_imm  = {{20{dec_instr[31]}}, dec_instr[31:25], dec_instr[11:7]};

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_deq) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (!dec_valid) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule
